// File: rtl/rf_wb_sink.sv
// Architectural register file with write-through bypass, plus a per-register
// pending-write scoreboard that raises a RAW/saturation stall toward the D stage.
module rf_wb_sink #(
    parameter int N_BITS = 32,
    parameter int N_REGS = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [N_BITS-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [N_BITS-1:0] rs1_data,
    output logic [N_BITS-1:0] rs2_data,
    input  logic              iss_valid,
    input  logic              iss_rs1_ren,
    input  logic              iss_rs2_ren,
    input  logic              iss_rd_wen,
    input  logic [ADDR_W-1:0] iss_rd_addr,
    output logic              stall,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_BITS-1:0] regs_q [N_REGS];
    logic [CNT_W-1:0]  pend_q [N_REGS];
    logic [CNT_W-1:0]  pend_d [N_REGS];
    logic              sb_err_q, sb_err_d;

    logic [N_REGS-1:0] inc, dec, busy;
    logic              hazard1, hazard2, sat, fire;

    function automatic logic [N_BITS-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [N_BITS-1:0] wdata,
        input logic [N_BITS-1:0] arr_val
    );
        if (addr == '0)
            return '0;
        else if (we && (waddr == addr))
            return wdata;
        else
            return arr_val;
    endfunction

    assign rs1_data = read_port(rs1_addr, wb_en, wb_addr, wb_data, regs_q[rs1_addr]);
    assign rs2_data = read_port(rs2_addr, wb_en, wb_addr, wb_data, regs_q[rs2_addr]);

    // A write-back landing this cycle retires one pending write, so it no longer blocks.
    always_comb begin
        dec  = '0;
        busy = '0;
        for (int r = 1; r < N_REGS; r++) begin
            dec[r]  = wb_en && (wb_addr == ADDR_W'(r));
            busy[r] = (pend_q[r] > CNT_W'(1)) ||
                      ((pend_q[r] == CNT_W'(1)) && !dec[r]);
        end
    end

    assign hazard1 = iss_rs1_ren && busy[rs1_addr];
    assign hazard2 = iss_rs2_ren && busy[rs2_addr];
    assign sat     = iss_rd_wen && (iss_rd_addr != '0) &&
                     (pend_q[iss_rd_addr] == CNT_MAX) && !dec[iss_rd_addr];
    assign stall   = iss_valid && (hazard1 || hazard2 || sat);
    assign fire    = iss_valid && !stall;

    always_comb begin
        inc      = '0;
        sb_err_d = sb_err_q;
        for (int r = 0; r < N_REGS; r++) begin
            pend_d[r] = pend_q[r];
        end
        for (int r = 1; r < N_REGS; r++) begin
            inc[r] = fire && iss_rd_wen && (iss_rd_addr == ADDR_W'(r));
            if (inc[r] && !dec[r]) begin
                if (pend_q[r] == CNT_MAX)
                    sb_err_d = 1'b1;
                else
                    pend_d[r] = pend_q[r] + CNT_W'(1);
            end else if (dec[r] && !inc[r]) begin
                if (pend_q[r] == '0)
                    sb_err_d = 1'b1;
                else
                    pend_d[r] = pend_q[r] - CNT_W'(1);
            end
        end
        pend_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err_q <= 1'b0;
            for (int r = 0; r < N_REGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            sb_err_q <= sb_err_d;
            for (int r = 0; r < N_REGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            if (wb_en && (wb_addr != '0))
                regs_q[wb_addr] <= wb_data;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_rf_wb_sink.sv
// Directed and randomized bench for rf_wb_sink against an array-based reference model.
module tb_rf_wb_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        iss_valid, iss_rs1_ren, iss_rs2_ren, iss_rd_wen;
    logic [4:0]  iss_rd_addr;
    logic        stall, sb_err;

    int checks = 0;
    int errors = 0;

    // Reference state: plain register contents, outstanding write counts, error flag.
    logic [31:0] m_regs [32];
    int          m_pend [32];
    logic        m_err;

    rf_wb_sink dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .iss_valid(iss_valid), .iss_rs1_ren(iss_rs1_ren), .iss_rs2_ren(iss_rs2_ren),
        .iss_rd_wen(iss_rd_wen), .iss_rd_addr(iss_rd_addr),
        .stall(stall), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic logic wb_hits(int a);
        return wb_en && (int'(wb_addr) == a);
    endfunction

    function automatic logic [31:0] m_read(int a);
        if (a == 0) return 32'h0;
        if (wb_hits(a)) return wb_data;
        return m_regs[a];
    endfunction

    // Register still owed a write after whatever write-back arrives this cycle.
    function automatic logic m_waiting(int a);
        int left;
        if (a == 0) return 1'b0;
        left = m_pend[a] - (wb_hits(a) ? 1 : 0);
        return left > 0;
    endfunction

    function automatic logic m_stall();
        logic full;
        full = iss_rd_wen && (iss_rd_addr != 0) &&
               (m_pend[iss_rd_addr] >= 3) && !wb_hits(int'(iss_rd_addr));
        return iss_valid && ((iss_rs1_ren && m_waiting(int'(rs1_addr))) ||
                             (iss_rs2_ren && m_waiting(int'(rs2_addr))) || full);
    endfunction

    task automatic m_clock();
        logic issued;
        int   d;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'h0;
                m_pend[r] = 0;
            end
            m_err = 1'b0;
            return;
        end
        issued = iss_valid && !m_stall();
        for (int r = 1; r < 32; r++) begin
            d = 0;
            if (issued && iss_rd_wen && int'(iss_rd_addr) == r) d = d + 1;
            if (wb_hits(r)) d = d - 1;
            if (m_pend[r] + d < 0 || m_pend[r] + d > 3) m_err = 1'b1;
            else m_pend[r] = m_pend[r] + d;
        end
        if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(string tag);
        #1;
        chk({tag, ".rs1"}, rs1_data, m_read(int'(rs1_addr)));
        chk({tag, ".rs2"}, rs2_data, m_read(int'(rs2_addr)));
        chk({tag, ".stall"}, {31'h0, stall}, {31'h0, m_stall()});
        chk({tag, ".sb_err"}, {31'h0, sb_err}, {31'h0, m_err});
        @(posedge clk);
        m_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        rs1_addr = 0; rs2_addr = 0;
        iss_valid = 0; iss_rs1_ren = 0; iss_rs2_ren = 0; iss_rd_wen = 0; iss_rd_addr = 0;
    endtask

    task automatic issue_rd(int rd);
        idle(); iss_valid = 1; iss_rd_wen = 1; iss_rd_addr = 5'(rd);
    endtask

    initial begin
        int pick;
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'hX; m_pend[r] = 0;
        end
        m_err = 1'b0;
        idle(); rst = 1;
        @(negedge clk);
        cyc("reset");

        idle();
        for (int r = 0; r < 32; r++) begin
            rs1_addr = 5'(r); rs2_addr = 5'(31 - r);
            #1 chk("reset_read", rs1_data, 32'h0);
            cyc("read_all");
        end
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_err", {31'h0, sb_err}, 32'h0);

        wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; cyc("wr_x5");
        idle(); rs1_addr = 5;
        #1 chk("rd_x5", rs1_data, 32'hDEADBEEF);
        wb_en = 1; wb_addr = 0; wb_data = 32'h1234; rs1_addr = 0;
        #1 chk("wr_x0_bypass", rs1_data, 32'h0);
        cyc("wr_x0");
        idle(); rs1_addr = 0;
        #1 chk("rd_x0", rs1_data, 32'h0);
        cyc("rd_x0");

        idle(); wb_en = 1; wb_addr = 9; wb_data = 32'hA5A5A5A5; rs2_addr = 9;
        #1 chk("bypass_x9", rs2_data, 32'hA5A5A5A5);
        cyc("bypass");

        issue_rd(7); cyc("iss_x7");
        idle(); iss_valid = 1; iss_rs1_ren = 1; rs1_addr = 7;
        #1 chk("raw_stall0", {31'h0, stall}, 32'h1);
        cyc("raw0");
        #1 chk("raw_stall1", {31'h0, stall}, 32'h1);
        cyc("raw1");
        wb_en = 1; wb_addr = 7; wb_data = 32'h0000_7777;
        #1 chk("raw_release", {31'h0, stall}, 32'h0);
        chk("raw_bypass", rs1_data, 32'h0000_7777);
        cyc("raw_wb");
        wb_en = 0;
        #1 chk("raw_cleared", {31'h0, stall}, 32'h0);
        cyc("raw_after");

        for (int i = 0; i < 3; i++) begin
            issue_rd(3); cyc("fill_x3");
        end
        issue_rd(3);
        #1 chk("sat_stall", {31'h0, stall}, 32'h1);
        cyc("sat");
        wb_en = 1; wb_addr = 3; wb_data = 32'h3333_0003;
        #1 chk("sat_wb_release", {31'h0, stall}, 32'h0);
        cyc("sat_wb");
        issue_rd(3);
        #1 chk("sat_still_full", {31'h0, stall}, 32'h1);
        cyc("sat_again");

        idle(); wb_en = 1; wb_addr = 4; wb_data = 32'h4444_4444; cyc("underflow");
        idle(); rs1_addr = 4;
        #1 chk("err_set", {31'h0, sb_err}, 32'h1);
        chk("x4_written", rs1_data, 32'h4444_4444);
        cyc("err_hold0");
        #1 chk("err_sticky", {31'h0, sb_err}, 32'h1);
        cyc("err_hold1");

        issue_rd(7); cyc("p7a");
        issue_rd(7); cyc("p7b");
        idle(); rst = 1; iss_valid = 1; iss_rd_wen = 1; iss_rd_addr = 7;
        cyc("mid_reset");
        idle(); iss_valid = 1; iss_rs1_ren = 1; rs1_addr = 7;
        #1 chk("post_rst_stall", {31'h0, stall}, 32'h0);
        chk("post_rst_err", {31'h0, sb_err}, 32'h0);
        chk("post_rst_x7", rs1_data, 32'h0);
        cyc("post_rst");

        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            iss_valid   = $urandom_range(0, 1);
            iss_rs1_ren = $urandom_range(0, 1);
            iss_rs2_ren = $urandom_range(0, 1);
            iss_rd_wen  = $urandom_range(0, 1);
            iss_rd_addr = 5'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 7));
            wb_en       = ($urandom_range(0, 9) < 4);
            wb_data     = $urandom;
            wb_addr     = 5'($urandom_range(0, 31));
            pick        = $urandom_range(0, 7);
            if ($urandom_range(0, 9) < 8)
                for (int k = 0; k < 8; k++)
                    if (m_pend[(pick + k) % 8] > 0) wb_addr = 5'((pick + k) % 8);
            cyc("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_sink.md
Name: rf_wb_sink

Overview:
- Register file and write-back scoreboard: the receiving end of the write-back packet (enable, address, data) produced by the W stage.
- Commits write-back data into a 32-entry architectural register file.
- Serves two combinational read ports to the D stage, with write-through bypass.
- Tracks in-flight destination writes per register so D can stall on RAW hazards until the matching write-back arrives.

Parameters:
- N_BITS, 32, data width of each register.
- N_REGS, 32, number of architectural registers (x0 hardwired zero).
- ADDR_W, 5, register address width, equal to clog2(N_REGS).
- CNT_W, 2, width of per-register pending-write counter; max in-flight writes per register is 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_en  in  1  write-back enable from W stage.
- wb_addr  in  ADDR_W  write-back destination register.
- wb_data  in  N_BITS  write-back data.
- rs1_addr  in  ADDR_W  read port 1 address.
- rs2_addr  in  ADDR_W  read port 2 address.
- rs1_data  out  N_BITS  read port 1 data (combinational).
- rs2_data  out  N_BITS  read port 2 data (combinational).
- iss_valid  in  1  D stage presents an instruction for issue.
- iss_rs1_ren  in  1  issuing instruction reads rs1.
- iss_rs2_ren  in  1  issuing instruction reads rs2.
- iss_rd_wen  in  1  issuing instruction writes rd.
- iss_rd_addr  in  ADDR_W  issuing instruction destination.
- stall  out  1  hazard; issue must not proceed this cycle (combinational).
- sb_err  out  1  sticky scoreboard error (underflow or overflow).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset (rst=1 at posedge): all registers, all pending counters and sb_err go to 0. Any in-flight writes are dropped. rst overrides every same-cycle write, issue and error event. Outputs after reset: rs*_data=0, stall=0 (while iss_valid=0), sb_err=0.
- Write:
  - At posedge, if wb_en=1 and wb_addr!=0, then reg[wb_addr] <= wb_data.
  - A write to x0 is discarded.
  - Write latency: visible in the array the next cycle; visible on the same cycle through the bypass.
- Read, per port, priority order:
  - addr==0 -> 0.
  - else wb_en=1 and wb_addr==addr -> wb_data (write-through bypass).
  - else reg[addr].
- Issue fire: fire = iss_valid & ~stall.
- Pending counter pend[r], for r=1..N_REGS-1:
  - inc = fire & iss_rd_wen & (iss_rd_addr==r) & (r!=0).
  - dec = wb_en & (wb_addr==r) & (r!=0).
  - inc & dec -> unchanged.
  - inc only -> +1.
  - dec only -> -1.
  - dec only with pend[r]==0 -> unchanged; set sb_err.
  - pend[0] is constant 0.
- Effective busy for register r (r!=0): pend[r]>1, or (pend[r]==1 and not dec for r). A same-cycle write-back therefore clears the hazard, and the bypass supplies the data.
- stall = iss_valid & (hazard1 | hazard2 | sat), where:
  - hazard1 = iss_rs1_ren & busy(rs1_addr).
  - hazard2 = iss_rs2_ren & busy(rs2_addr).
  - sat = iss_rd_wen & iss_rd_addr!=0 & pend[iss_rd_addr]==max & no same-cycle dec for it.
  - The iss_rd_addr==0 case never stalls on sat.
- Overflow: the sat stall prevents counter overflow. If an increment would still exceed max, the counter holds and sb_err is set (defensive).
- sb_err is sticky until rst.
- stall=0 whenever iss_valid=0.
- rs1_addr and rs2_addr are the hazard-check addresses; D drives them with the issuing instruction's sources.

Test Plan:
- Reset, then read x0..x31 -> all 0; stall=0; sb_err=0.
- Write x5=0xDEADBEEF, then read x5 next cycle -> 0xDEADBEEF. Write x0=0x1234 -> rs1_data with rs1_addr=0 reads 0.
- Same-cycle bypass: wb_en=1, wb_addr=9, wb_data=0xA5A5A5A5 with rs2_addr=9 -> rs2_data=0xA5A5A5A5 in that cycle, before the array updates.
- Issue rd=x7 (fire). Next cycle iss_valid=1 with rs1=x7, rs1_ren=1 -> stall=1 and stays 1 until the cycle wb_en=1, wb_addr=7, where stall=0 and rs1_data=wb_data. pend[7]=0 afterwards.
- Issue rd=x3 three times with no write-back -> pend[3]=3. Fourth issue with rd=x3 -> stall=1. Same cycle with wb x3 -> stall=0 and pend stays 3.
- wb_en=1, wb_addr=4 with pend[4]=0 -> sb_err=1 next cycle and held. Reg x4 is still written. rst=1 -> sb_err=0 and all pend cleared. Mid-operation reset with pend[7]=2 -> after reset, reads of x7 with rs1_ren do not stall.
